fshift_lpf_ctrl: RTL and testbench

FSHIFT_LPF_CTRL -- requirements
Module: fshift_lpf_ctrl

---
 rtl/fshift_lpf_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fshift_lpf_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fshift_lpf_ctrl.sv
// Frequency-shift NCO phase source and LPF coefficient reload controller.
// Gates the IQ stream off while a new FIR coefficient set is streamed out.
module fshift_lpf_ctrl #(
  parameter int PHASE_WIDTH      = 24,
  parameter int SCALING_WIDTH    = 18,
  parameter int COEFF_WIDTH      = 16,
  parameter int NUM_COEFFS       = 128,
  parameter int SYMMETRIC_COEFFS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic [1:0]               cfg_addr,
  input  logic [31:0]              cfg_wr_data,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [PHASE_WIDTH-1:0]   phase_tdata,
  output logic                     phase_tvalid,
  input  logic                     phase_tready,
  output logic [SCALING_WIDTH-1:0] scaling_tdata,
  output logic [COEFF_WIDTH-1:0]   coeff_out,
  output logic                     reload_tvalid,
  output logic                     reload_tlast,
  output logic                     busy,
  output logic                     cfg_err
);

  localparam int NLOAD =
    (SYMMETRIC_COEFFS == 1) ? NUM_COEFFS / 2 : NUM_COEFFS;
  localparam int AW = (NLOAD > 1) ? $clog2(NLOAD) : 1;
  localparam int CW = $clog2(NLOAD + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NLOAD - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NLOAD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RELOAD = 2'd1,
    RUN    = 2'd2
  } state_e;

  // Async assert, 2-flop synchronized release.
  logic [1:0] rsync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync_q <= '0;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_n = rsync_q[1];

  logic wr_ph, wr_scl, wr_coef, wr_ctrl;

  always_comb begin
    wr_ph   = 1'b0;
    wr_scl  = 1'b0;
    wr_coef = 1'b0;
    wr_ctrl = 1'b0;
    if (cfg_wr_en) begin
      unique case (cfg_addr)
        2'd0: wr_ph   = 1'b1;
        2'd1: wr_scl  = 1'b1;
        2'd2: wr_coef = 1'b1;
        2'd3: wr_ctrl = 1'b1;
        default: ;
      endcase
    end
  end

  state_e                   state_q, state_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]   acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]   inc_q, inc_d;
  logic [SCALING_WIDTH-1:0] scl_q, scl_d;
  logic                     en_q, en_d;
  logic                     neg_q, neg_d;
  logic                     start_q, start_d;
  logic                     err_q, err_d;
  logic [COEFF_WIDTH-1:0]   coef_q [NLOAD];

  logic is_reload, is_run, last, full, start_bad;

  assign is_reload = (state_q == RELOAD);
  assign is_run    = (state_q == RUN);
  assign last      = is_reload && (rd_ptr_q == LAST_IDX);
  assign full      = (cnt_q == FULL_CNT);

  always_comb begin
    state_d   = state_q;
    start_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_q && full)  state_d = RELOAD;
        else if (start_q)     start_bad = 1'b1;
        else if (en_q)        state_d = RUN;
      end
      RUN: begin
        if (start_q && !full) start_bad = 1'b1;
        if (start_q && full)  state_d = RELOAD;
        else if (!en_q)       state_d = IDLE;
      end
      RELOAD: begin
        if (last) state_d = en_q ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = (is_reload && !last) ? rd_ptr_q + AW'(1) : '0;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (last) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (wr_coef && !is_reload) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end

    acc_d = acc_q;
    if (wr_ctrl && cfg_wr_data[2]) acc_d = '0;
    else if (is_run && phase_tready)
      acc_d = neg_q ? acc_q - inc_q : acc_q + inc_q;

    // A new error wins over a same-cycle clear.
    err_d = err_q;
    if (start_bad || (wr_coef && is_reload)) err_d = 1'b1;
    else if (wr_ctrl && cfg_wr_data[4])      err_d = 1'b0;

    start_d = wr_ctrl && cfg_wr_data[0];
    en_d    = wr_ctrl ? cfg_wr_data[1] : en_q;
    neg_d   = wr_ctrl ? cfg_wr_data[3] : neg_q;
    inc_d   = wr_ph  ? cfg_wr_data[PHASE_WIDTH-1:0]   : inc_q;
    scl_d   = wr_scl ? cfg_wr_data[SCALING_WIDTH-1:0] : scl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      inc_q    <= '0;
      scl_q    <= '0;
      en_q     <= 1'b0;
      neg_q    <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      scl_q    <= scl_d;
      en_q     <= en_d;
      neg_q    <= neg_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_coef && !is_reload)
      coef_q[wr_ptr_q] <= cfg_wr_data[COEFF_WIDTH-1:0];
  end

  assign s_tready      = m_tready & is_run;
  assign m_tvalid      = s_tvalid & is_run;
  assign phase_tvalid  = is_run;
  assign phase_tdata   = acc_q;
  assign scaling_tdata = scl_q;
  assign coeff_out     = is_reload ? coef_q[rd_ptr_q] : '0;
  assign reload_tvalid = is_reload;
  assign reload_tlast  = last;
  assign busy          = is_reload;
  assign cfg_err       = err_q;

  logic unused_wdata;
  assign unused_wdata = ^cfg_wr_data;

endmodule

// File: tb/tb_fshift_lpf_ctrl.sv
// Bench for fshift_lpf_ctrl: vector table, directed sequences,
// and randomized traffic against a behavioural model.
module tb_fshift_lpf_ctrl;

  localparam int NL = 64;
  localparam logic [31:0] C_START = 32'd1;
  localparam logic [31:0] C_EN    = 32'd2;
  localparam logic [31:0] C_PCLR  = 32'd4;
  localparam logic [31:0] C_NEG   = 32'd8;
  localparam logic [31:0] C_ECLR  = 32'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wr_data = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [23:0] phase_tdata;
  logic        phase_tvalid;
  logic        phase_tready = 1'b0;
  logic [17:0] scaling_tdata;
  logic [15:0] coeff_out;
  logic        reload_tvalid;
  logic        reload_tlast;
  logic        busy;
  logic        cfg_err;

  always #5 clk = ~clk;

  fshift_lpf_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid),
    .phase_tready(phase_tready),
    .scaling_tdata(scaling_tdata), .coeff_out(coeff_out),
    .reload_tvalid(reload_tvalid), .reload_tlast(reload_tlast),
    .busy(busy), .cfg_err(cfg_err)
  );

  logic [64:0] outv;
  assign outv = {phase_tdata, phase_tvalid, scaling_tdata, coeff_out,
                 reload_tvalid, reload_tlast, busy, cfg_err,
                 s_tready, m_tvalid};

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr = a;
    cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  // Behavioural model
  logic [15:0] mbuf [NL];
  logic [15:0] rq [$];
  int          mmode;
  int          mwr, mcnt;
  logic [23:0] macc, minc;
  logic [17:0] mscl;
  bit          men, mneg, merr, mstart;

  task automatic model_init();
    mmode = 0; mwr = 0; mcnt = 0;
    macc = '0; minc = '0; mscl = '0;
    men = 0; mneg = 0; merr = 0; mstart = 0;
    rq.delete();
  endtask

  function automatic logic [64:0] model_out();
    logic [15:0] c = '0;
    bit v = 0;
    bit l = 0;
    if (mmode == 1) begin
      v = 1; c = rq[0]; l = (rq.size() == 1);
    end
    return {macc, mmode == 2, mscl, c, v, l, v, merr,
            m_tready && mmode == 2, s_tvalid && mmode == 2};
  endfunction

  task automatic model_step();
    bit bad = 0;
    bit go = 0;
    int nmode = mmode;
    bit wc = cfg_wr_en && cfg_addr == 2'd3;
    bit wk = cfg_wr_en && cfg_addr == 2'd2;
    if (mmode == 1) begin
      void'(rq.pop_front());
      if (rq.size() == 0) nmode = men ? 2 : 0;
    end else if (mstart) begin
      if (mcnt == NL) begin go = 1; nmode = 1; end
      else bad = 1;
      if (!go && mmode == 2 && !men) nmode = 0;
    end else if (mmode == 0 && men) nmode = 2;
    else if (mmode == 2 && !men) nmode = 0;
    if (wc && cfg_wr_data[2]) macc = '0;
    else if (mmode == 2 && phase_tready)
      macc = mneg ? macc - minc : macc + minc;
    if (wk) begin
      if (mmode == 1) bad = 1;
      else begin
        mbuf[mwr] = cfg_wr_data[15:0];
        mwr = (mwr + 1) % NL;
        if (mcnt < NL) mcnt++;
      end
    end
    if (mmode == 1 && nmode != 1) begin mwr = 0; mcnt = 0; end
    if (bad) merr = 1;
    else if (wc && cfg_wr_data[4]) merr = 0;
    mstart = wc && cfg_wr_data[0];
    if (wc) begin men = cfg_wr_data[1]; mneg = cfg_wr_data[3]; end
    if (cfg_wr_en && cfg_addr == 2'd0) minc = cfg_wr_data[23:0];
    if (cfg_wr_en && cfg_addr == 2'd1) mscl = cfg_wr_data[17:0];
    if (go) for (int i = 0; i < NL; i++) rq.push_back(mbuf[i]);
    mmode = nmode;
  endtask

  typedef struct {
    bit          en;
    bit          sv;
    bit          mr;
    logic [17:0] scl;
    logic [2:0]  exp_g;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [23:0] e;
    logic [23:0] p;
    logic [31:0] d;
    int r;

    vt[0] = '{0, 1, 1, 18'h2ABCD, 3'b000};
    vt[1] = '{1, 1, 1, 18'h00001, 3'b111};
    vt[2] = '{1, 0, 1, 18'h3FFFF, 3'b101};
    vt[3] = '{1, 1, 0, 18'h12345, 3'b011};
    vt[4] = '{1, 0, 0, 18'h20000, 3'b001};
    vt[5] = '{0, 0, 1, 18'h0F0F0, 3'b000};

    // Reset values with IQ traffic present
    s_tvalid = 1; m_tready = 1; phase_tready = 1;
    tick(); tick();
    check("reset_outputs", outv, 65'd0);
    reset = 1'b1;
    repeat (3) tick();

    // IQ gating and scaling table
    for (int i = 0; i < 6; i++) begin
      s_tvalid = 0; m_tready = 0;
      wr(2'd1, 32'(vt[i].scl));
      check("scaling_1cyc", 128'(scaling_tdata), 128'(vt[i].scl));
      wr(2'd3, vt[i].en ? C_EN : 32'd0);
      tick(); tick();
      s_tvalid = vt[i].sv; m_tready = vt[i].mr;
      #1;
      check("gate_vec", {s_tready, m_tvalid, phase_tvalid},
            128'(vt[i].exp_g));
    end
    s_tvalid = 0; m_tready = 0;

    // Full load and reload, ENABLE=0
    for (int i = 1; i <= NL; i++) wr(2'd2, 32'(i));
    check("load_no_err", 128'(cfg_err), 128'd0);
    wr(2'd3, C_START);
    check("reload_latency", 128'(reload_tvalid), 128'd0);
    tick();
    for (int i = 0; i < NL; i++) begin
      check("reload_beat",
            {reload_tvalid, reload_tlast, busy, coeff_out},
            {1'b1, i == NL - 1, 1'b1, 16'(i + 1)});
      tick();
    end
    check("reload_done",
          {reload_tvalid, reload_tlast, busy, phase_tvalid}, 128'd0);

    // Negative shift sweep
    phase_tready = 1;
    wr(2'd0, 32'd1024);
    wr(2'd3, C_EN | C_NEG);
    check("run_not_yet", 128'(phase_tvalid), 128'd0);
    tick();
    e = 24'd0;
    for (int k = 0; k < 8; k++) begin
      check("neg_sweep", {phase_tvalid, phase_tdata}, {1'b1, e});
      e = e - 24'd1024;
      tick();
    end

    // Stall with PH_INC change mid-stall
    phase_tready = 0;
    p = phase_tdata;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wr(2'd0, 32'd2048);
      else tick();
      check("stall_hold", 128'(phase_tdata), 128'(p));
    end
    phase_tready = 1;
    tick();
    check("stall_step", 128'(phase_tdata), 128'(p - 24'd2048));

    // Reload from RUN with IQ traffic
    s_tvalid = 1; m_tready = 1;
    for (int i = 0; i < NL; i++) wr(2'd2, 32'h100 + 32'(i));
    check("iq_open", {s_tready, m_tvalid}, 128'd3);
    wr(2'd3, C_EN | C_START);
    tick();
    p = phase_tdata;
    for (int i = 0; i < NL; i++) begin
      check("run_reload",
            {s_tready, m_tvalid, busy, reload_tvalid, reload_tlast,
             coeff_out},
            {2'b00, 2'b11, i == NL - 1, 16'h100 + 16'(i)});
      check("phase_frozen", 128'(phase_tdata), 128'(p));
      tick();
    end
    check("iq_resume", {s_tready, m_tvalid, phase_tvalid, busy},
          128'(4'b1110));
    check("phase_resume_hold", 128'(phase_tdata), 128'(p));
    tick();
    check("phase_resume_step", 128'(phase_tdata), 128'(p + 24'd2048));

    // Partial load rejected
    for (int i = 0; i < 10; i++) wr(2'd2, 32'(i));
    wr(2'd3, C_EN | C_START);
    check("bad_start_lat", 128'(reload_tvalid), 128'd0);
    tick();
    check("bad_start", {cfg_err, reload_tvalid, phase_tvalid},
          128'(3'b101));
    repeat (3) begin
      tick();
      check("bad_start_quiet", {reload_tvalid, busy}, 128'd0);
    end
    wr(2'd3, C_EN | C_ECLR);
    check("err_clr", {cfg_err, phase_tvalid}, 128'(2'b01));
    wr(2'd3, C_EN | C_START);
    wr(2'd3, C_EN | C_ECLR);
    check("err_priority", 128'(cfg_err), 128'd1);
    wr(2'd3, C_EN | C_ECLR);
    check("err_clr2", 128'(cfg_err), 128'd0);

    // Reset mid-reload
    for (int i = 0; i < NL - 10; i++) wr(2'd2, 32'h200 + 32'(i));
    wr(2'd3, C_START);
    tick();
    repeat (20) tick();
    check("beat20", {reload_tvalid, busy, reload_tlast, coeff_out},
          {3'b110, 16'h20A});
    reset = 1'b0;
    #1;
    check("reset_abort", outv, 65'd0);
    tick();
    check("reset_hold", outv, 65'd0);
    reset = 1'b1;
    repeat (3) tick();
    wr(2'd3, C_START);
    tick();
    check("post_reset_start", {cfg_err, reload_tvalid, busy},
          128'(3'b100));
    tick();
    check("post_reset_quiet", {reload_tvalid, reload_tlast}, 128'd0);

    // Randomized traffic against the model
    cfg_wr_en = 0;
    do_reset();
    model_init();
    for (int c = 0; c < 3000; c++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      phase_tready = 1'($urandom_range(0, 1));
      cfg_wr_en = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 9);
      cfg_addr = (r < 6) ? 2'd2 : (r < 7) ? 2'd0 : (r < 8) ? 2'd1 : 2'd3;
      d = $urandom();
      if (cfg_addr == 2'd3)
        d = {d[31:5], ($urandom_range(0, 7) == 0), d[3],
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             d[0]};
      cfg_wr_data = d;
      #1;
      check("rand", outv, model_out());
      model_step();
      @(posedge clk);
      #1;
    end
    cfg_wr_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
